// File: rtl/axi4_lite_slave_mem.sv
// axi4_lite_slave_mem: AXI4-Lite responder over a bank of NUM_REGS 32-bit registers.
// Independent write (collect/commit/respond) and read (idle/data) FSMs, all outputs registered.
module axi4_lite_slave_mem #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int NUM_REGS = 32
) (
  input  logic                ACLK,
  input  logic                ARESET,
  input  logic [ADDR_W-1:0]   AWADDR,
  input  logic                AWVALID,
  output logic                AWREADY,
  input  logic [DATA_W-1:0]   WDATA,
  input  logic [DATA_W/8-1:0] WSTRB,
  input  logic                WVALID,
  output logic                WREADY,
  output logic [1:0]          BRESP,
  output logic                BVALID,
  input  logic                BREADY,
  input  logic [ADDR_W-1:0]   ARADDR,
  input  logic                ARVALID,
  output logic                ARREADY,
  output logic [DATA_W-1:0]   RDATA,
  output logic [1:0]          RRESP,
  output logic                RVALID,
  input  logic                RREADY
);
  localparam int IDX_W = $clog2(NUM_REGS);
  localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(NUM_REGS * 4);
  typedef enum logic [1:0] {W_COLLECT, W_COMMIT, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;
  w_state_t w_state;
  r_state_t r_state;
  logic [DATA_W-1:0] regs [NUM_REGS];
  logic aw_got, w_got, aw_err, aw_hs, w_hs, aw_n, w_n, ar_hs;
  logic [IDX_W-1:0] aw_idx;
  logic [DATA_W-1:0] w_data;
  logic [DATA_W/8-1:0] w_strb;
  assign aw_hs = AWVALID && AWREADY;
  assign w_hs = WVALID && WREADY;
  assign ar_hs = ARVALID && ARREADY;
  assign aw_n = aw_got || aw_hs;
  assign w_n = w_got || w_hs;
  // Range is decided at capture so only the word index and an error flag are held.
  always_ff @(posedge ACLK or posedge ARESET)
    if (ARESET) begin
      w_state <= W_COLLECT;
      aw_got <= 1'b0;
      w_got <= 1'b0;
      aw_err <= 1'b0;
      aw_idx <= '0;
      w_data <= '0;
      w_strb <= '0;
      AWREADY <= 1'b0;
      WREADY <= 1'b0;
      BVALID <= 1'b0;
      BRESP <= 2'b00;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else
      case (w_state)
        W_COLLECT: begin
          if (aw_hs) begin
            aw_idx <= AWADDR[2 +: IDX_W];
            aw_err <= AWADDR >= LIMIT;
          end
          if (w_hs) begin
            w_data <= WDATA;
            w_strb <= WSTRB;
          end
          aw_got <= aw_n && !w_n;
          w_got <= w_n && !aw_n;
          AWREADY <= !aw_n;
          WREADY <= !w_n;
          w_state <= aw_n && w_n ? W_COMMIT : W_COLLECT;
        end
        W_COMMIT: begin
          if (!aw_err)
            for (int b = 0; b < DATA_W / 8; b++)
              if (w_strb[b]) regs[aw_idx][8*b +: 8] <= w_data[8*b +: 8];
          BRESP <= aw_err ? 2'b10 : 2'b00;
          BVALID <= 1'b1;
          w_state <= W_RESP;
        end
        W_RESP:
          if (BREADY) begin
            BVALID <= 1'b0;
            AWREADY <= 1'b1;
            WREADY <= 1'b1;
            w_state <= W_COLLECT;
          end
        default: w_state <= W_COLLECT;
      endcase
  // Reads sample the bank before any same-edge commit, so a racing read sees the old word.
  always_ff @(posedge ACLK or posedge ARESET)
    if (ARESET) begin
      r_state <= R_IDLE;
      ARREADY <= 1'b0;
      RVALID <= 1'b0;
      RRESP <= 2'b00;
      RDATA <= '0;
    end else
      case (r_state)
        R_IDLE:
          if (ar_hs) begin
            RDATA <= ARADDR < LIMIT ? regs[ARADDR[2 +: IDX_W]] : '0;
            RRESP <= ARADDR < LIMIT ? 2'b00 : 2'b10;
            RVALID <= 1'b1;
            ARREADY <= 1'b0;
            r_state <= R_DATA;
          end else ARREADY <= 1'b1;
        R_DATA:
          if (RREADY) begin
            RVALID <= 1'b0;
            ARREADY <= 1'b1;
            r_state <= R_IDLE;
          end
      endcase
endmodule

// File: tb/tb_axi4_lite_slave_mem.sv
// tb_axi4_lite_slave_mem: randomized scoreboard bench for axi4_lite_slave_mem.
// Responses expected from an array model are queued at issue and popped by negedge monitors.
module tb_axi4_lite_slave_mem;
  localparam int NR = 32;
  typedef struct {logic [1:0] resp; logic [31:0] data;} rsp_t;
  logic ACLK = 1'b0, ARESET = 1'b0;
  logic [31:0] AWADDR = '0, WDATA = '0, ARADDR = '0;
  logic [3:0] WSTRB = '0;
  logic AWVALID = 1'b0, WVALID = 1'b0, BREADY = 1'b0, ARVALID = 1'b0, RREADY = 1'b0;
  logic AWREADY, WREADY, BVALID, ARREADY, RVALID;
  logic [1:0] BRESP, RRESP;
  logic [31:0] RDATA;
  int n_checks = 0, n_fail = 0;
  logic [31:0] model [NR];
  logic [1:0] exp_b [$];
  rsp_t exp_r [$];

  always #5 ACLK = ~ACLK;

  axi4_lite_slave_mem #(.DATA_W(32), .ADDR_W(32), .NUM_REGS(NR)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  always @(negedge ACLK) begin
    logic [1:0] eb;
    rsp_t er;
    if (!ARESET && BVALID && BREADY) begin
      if (exp_b.size() == 0) timeout("b_unexpected");
      else begin
        eb = exp_b.pop_front();
        check("bresp", BRESP, eb);
      end
    end
    if (!ARESET && RVALID && RREADY) begin
      if (exp_r.size() == 0) timeout("r_unexpected");
      else begin
        er = exp_r.pop_front();
        check("rresp", RRESP, er.resp);
        check("rdata", RDATA, er.data);
      end
    end
  end

  function automatic bit in_range(input logic [31:0] a);
    return a < NR * 4;
  endfunction

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                    input int da, input int dw);
    bit aw_done = 0, w_done = 0, aw_hs, w_hs;
    int t = 0;
    if (in_range(a))
      for (int i = 0; i < 4; i++) if (s[i]) model[a >> 2][8*i +: 8] = d[8*i +: 8];
    exp_b.push_back(in_range(a) ? 2'b00 : 2'b10);
    while (!(aw_done && w_done)) begin
      if (!aw_done && t >= da) begin AWADDR = a; AWVALID = 1; end
      if (!w_done && t >= dw) begin WDATA = d; WSTRB = s; WVALID = 1; end
      @(negedge ACLK);
      aw_hs = AWVALID && AWREADY;
      w_hs = WVALID && WREADY;
      @(posedge ACLK); #1;
      if (aw_hs) begin aw_done = 1; AWVALID = 0; end
      if (w_hs) begin w_done = 1; WVALID = 0; end
      if (++t > 50) begin timeout("wr_accept"); AWVALID = 0; WVALID = 0; return; end
    end
    t = 0;
    forever begin
      BREADY = 1'($urandom_range(0, 1));
      @(negedge ACLK);
      if (BVALID && BREADY) break;
      @(posedge ACLK); #1;
      if (++t > 50) begin timeout("wr_bresp"); BREADY = 0; return; end
    end
    @(posedge ACLK); #1;
    BREADY = 0;
  endtask

  task automatic rd(input logic [31:0] a);
    rsp_t e;
    bit hs;
    int t = 0;
    e.resp = in_range(a) ? 2'b00 : 2'b10;
    e.data = '0;
    if (in_range(a)) e.data = model[a >> 2];
    exp_r.push_back(e);
    ARADDR = a;
    ARVALID = 1;
    forever begin
      @(negedge ACLK);
      hs = ARREADY;
      @(posedge ACLK); #1;
      if (hs) break;
      if (++t > 50) begin timeout("rd_accept"); ARVALID = 0; return; end
    end
    ARVALID = 0;
    t = 0;
    forever begin
      RREADY = 1'($urandom_range(0, 1));
      @(negedge ACLK);
      if (RVALID && RREADY) break;
      @(posedge ACLK); #1;
      if (++t > 50) begin timeout("rd_rresp"); RREADY = 0; return; end
    end
    @(posedge ACLK); #1;
    RREADY = 0;
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 5))
      0: return 32'h7C + $urandom_range(0, 3);
      1: return 32'h80 + $urandom_range(0, 3);
      2: return $urandom();
      default: return $urandom_range(0, NR * 4 - 1);
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rsp_t e;
    logic [31:0] old, bp_d, wa, ra, rw;
    int t;
    for (int i = 0; i < NR; i++) model[i] = '0;
    #1 ARESET = 1;
    repeat (3) @(posedge ACLK);
    #1;
    check("rst_awready", AWREADY, 0);
    check("rst_wready", WREADY, 0);
    check("rst_arready", ARREADY, 0);
    check("rst_bvalid", BVALID, 0);
    check("rst_rvalid", RVALID, 0);
    check("rst_bresp", BRESP, 0);
    check("rst_rresp", RRESP, 0);
    check("rst_rdata", RDATA, 0);
    ARESET = 0;
    @(posedge ACLK); #1;
    check("rel_awready", AWREADY, 1);
    check("rel_wready", WREADY, 1);
    check("rel_arready", ARREADY, 1);

    // write then read with exact latency
    model[7] = 32'h0DEADBEE;
    exp_b.push_back(2'b00);
    AWADDR = 32'h1C; WDATA = 32'h0DEADBEE; WSTRB = 4'hF; AWVALID = 1; WVALID = 1; BREADY = 1;
    @(posedge ACLK); #1;
    AWVALID = 0; WVALID = 0;
    check("hs_awready_drop", AWREADY, 0);
    check("hs_wready_drop", WREADY, 0);
    check("commit_bvalid_early", BVALID, 0);
    @(posedge ACLK); #1;
    check("commit_bvalid", BVALID, 1);
    check("commit_bresp", BRESP, 0);
    @(posedge ACLK); #1;
    check("b_done_bvalid", BVALID, 0);
    check("b_done_awready", AWREADY, 1);
    check("b_done_wready", WREADY, 1);
    BREADY = 0;
    e.resp = 2'b00; e.data = 32'h0DEADBEE; exp_r.push_back(e);
    ARADDR = 32'h1C; ARVALID = 1; RREADY = 1;
    @(posedge ACLK); #1;
    ARVALID = 0;
    check("rd_rvalid", RVALID, 1);
    check("rd_rdata", RDATA, 32'h0DEADBEE);
    check("rd_arready_drop", ARREADY, 0);
    @(posedge ACLK); #1;
    check("rd_done_rvalid", RVALID, 0);
    check("rd_done_arready", ARREADY, 1);
    RREADY = 0;

    // W two cycles ahead of AW, partial strobe
    wr(32'h1C, 32'hAABBCCDD, 4'b0101, 2, 0);
    rd(32'h1C);
    // boundaries, out-of-range and empty strobe
    wr(32'h7C, $urandom(), 4'hF, 0, 1);
    rd(32'h7C);
    wr(32'h80, $urandom(), 4'hF, 1, 0);
    rd(32'h80);
    rd(32'hFFFFFFFC);
    wr(32'h10, $urandom(), 4'h0, 0, 0);
    rd(32'h10);

    // backpressure on both channels
    bp_d = $urandom();
    model[3] = bp_d;
    exp_b.push_back(2'b00);
    e.resp = 2'b00; e.data = model[7]; exp_r.push_back(e);
    AWADDR = 32'h0C; WDATA = bp_d; WSTRB = 4'hF; AWVALID = 1; WVALID = 1;
    ARADDR = 32'h1C; ARVALID = 1; BREADY = 0; RREADY = 0;
    @(posedge ACLK); #1;
    AWVALID = 0; WVALID = 0; ARVALID = 0;
    check("bp_rvalid", RVALID, 1);
    check("bp_arready_drop", ARREADY, 0);
    @(posedge ACLK); #1;
    check("bp_bvalid", BVALID, 1);
    repeat (5) begin
      @(posedge ACLK); #1;
      check("bp_bvalid_hold", BVALID, 1);
      check("bp_bresp_hold", BRESP, 0);
      check("bp_rvalid_hold", RVALID, 1);
      check("bp_rdata_hold", RDATA, model[7]);
      check("bp_awready_low", AWREADY, 0);
      check("bp_arready_low", ARREADY, 0);
    end
    BREADY = 1; RREADY = 1;
    @(posedge ACLK); #1;
    check("bp_bvalid_clr", BVALID, 0);
    check("bp_rvalid_clr", RVALID, 0);
    check("bp_awready_up", AWREADY, 1);
    check("bp_arready_up", ARREADY, 1);
    BREADY = 0; RREADY = 0;
    rd(32'h0C);

    // read racing the commit edge returns the old word
    old = model[7];
    e.resp = 2'b00; e.data = old; exp_r.push_back(e);
    model[7] = 32'h0DEADBE0;
    exp_b.push_back(2'b00);
    AWADDR = 32'h1C; WDATA = 32'h0DEADBE0; WSTRB = 4'hF; AWVALID = 1; WVALID = 1;
    BREADY = 1; RREADY = 1;
    @(posedge ACLK); #1;
    AWVALID = 0; WVALID = 0; ARADDR = 32'h1C; ARVALID = 1;
    @(posedge ACLK); #1;
    ARVALID = 0;
    check("race_old", RDATA, old);
    check("race_bvalid", BVALID, 1);
    @(posedge ACLK); #1;
    BREADY = 0; RREADY = 0;
    rd(32'h1C);

    // randomized traffic, sometimes concurrent on disjoint words
    for (int n = 0; n < 80; n++) begin
      wa = rand_addr();
      case ($urandom_range(0, 2))
        0: wr(wa, $urandom(), 4'($urandom()), $urandom_range(0, 3), $urandom_range(0, 3));
        1: rd(wa);
        default: begin
          rw = ((((wa >> 2) % NR) + 1 + $urandom_range(0, NR - 2)) % NR);
          ra = (rw << 2) | 32'($urandom_range(0, 3));
          fork
            wr(wa, $urandom(), 4'($urandom()), $urandom_range(0, 3), $urandom_range(0, 3));
            rd(ra);
          join
        end
      endcase
    end

    // reset during a pending write response
    AWADDR = 32'h1C; WDATA = 32'h12345678; WSTRB = 4'hF; AWVALID = 1; WVALID = 1; BREADY = 0;
    @(posedge ACLK); #1;
    AWVALID = 0; WVALID = 0;
    t = 0;
    while (!BVALID && t < 20) begin @(posedge ACLK); #1; t++; end
    check("mid_bvalid_seen", BVALID, 1);
    #2 ARESET = 1;
    #1;
    check("mid_rst_bvalid", BVALID, 0);
    check("mid_rst_awready", AWREADY, 0);
    for (int i = 0; i < NR; i++) model[i] = '0;
    exp_b.delete();
    exp_r.delete();
    repeat (2) @(posedge ACLK);
    #1 ARESET = 0;
    rd(32'h1C);
    rd(32'h0C);

    repeat (3) @(posedge ACLK);
    check("b_queue_empty", exp_b.size(), 0);
    check("r_queue_empty", exp_r.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
